// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: boot-loads a streamed program into instruction memory at
// even word addresses, then fetches into IF/ID with stall, redirect and HALT handling.
module fetch_sequencer #(
    parameter int unsigned AW         = 16,
    parameter int unsigned LOAD_WORDS = 8,
    parameter logic [3:0]  HALT_OP    = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [15:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wdata,
    output logic          imem_we,
    input  logic [15:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [15:0]   if_instr,
    output logic          boot_done,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [AW-1:0] PC_STEP    = AW'(2);
    localparam logic [AW-1:0] PC_LSB     = AW'(1);
    localparam logic [AW-1:0] LOAD_LIMIT = AW'(2 * LOAD_WORDS);
    localparam logic [AW-1:0] LAST_PTR   = AW'(2 * (LOAD_WORDS - 1));

    // Instructions are word aligned, so a redirect target never keeps bit 0.
    function automatic logic [AW-1:0] align_pc(input logic [AW-1:0] pc);
        return pc & ~PC_LSB;
    endfunction

    function automatic logic is_halt(input logic [3:0] opcode);
        return (opcode == HALT_OP);
    endfunction

    state_e        state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] load_ptr_r;
    logic          if_valid_r;
    logic [AW-1:0] if_pc_r;
    logic [15:0]   if_instr_r;
    logic          boot_done_r;
    logic          halted_r;

    logic          load_ready_s;
    logic          accept_s;
    logic [AW-1:0] imem_addr_s;
    logic [15:0]   imem_wdata_s;

    // Memory port steering: boot writes go straight through so they land on the accept edge.
    always_comb begin
        load_ready_s = 1'b0;
        imem_addr_s  = pc_r;
        imem_wdata_s = 16'h0000;
        case (state_r)
            ST_LOAD: begin
                if (load_ptr_r < LOAD_LIMIT) begin
                    load_ready_s = 1'b1;
                end else begin
                    load_ready_s = 1'b0;
                end
                imem_addr_s  = load_ptr_r;
                imem_wdata_s = load_data;
            end
            ST_RUN, ST_HALT: begin
                imem_addr_s  = pc_r;
            end
            default: begin
                imem_addr_s  = pc_r;
            end
        endcase
        accept_s = load_valid & load_ready_s;
    end

    assign load_ready = load_ready_s;
    assign imem_we    = accept_s;
    assign imem_addr  = imem_addr_s;
    assign imem_wdata = imem_wdata_s;

    // Sequencer state, program counter and the IF/ID boundary register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            pc_r        <= '0;
            load_ptr_r  <= '0;
            if_valid_r  <= 1'b0;
            if_pc_r     <= '0;
            if_instr_r  <= 16'h0000;
            boot_done_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        load_ptr_r <= load_ptr_r + PC_STEP;
                        if (load_last || (load_ptr_r == LAST_PTR)) begin
                            state_r     <= ST_RUN;
                            pc_r        <= '0;
                            boot_done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_r       <= align_pc(redirect_pc);
                        if_valid_r <= 1'b0;
                    end else if (!stall) begin
                        if_pc_r    <= pc_r;
                        if_instr_r <= imem_rdata;
                        if_valid_r <= 1'b1;
                        pc_r       <= pc_r + PC_STEP;
                        if (is_halt(imem_rdata[15:12])) begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        state_r    <= ST_RUN;
                        halted_r   <= 1'b0;
                        pc_r       <= align_pc(redirect_pc);
                        if_valid_r <= 1'b0;
                    end else if (!stall) begin
                        if_valid_r <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean boot state.
                    state_r     <= ST_LOAD;
                    pc_r        <= '0;
                    load_ptr_r  <= '0;
                    if_valid_r  <= 1'b0;
                    boot_done_r <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_instr  = if_instr_r;
    assign boot_done = boot_done_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed boot/stall/redirect/HALT steps plus a random
// RUN phase, all checked cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        boot_done;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = loading, 1 = fetching, 2 = halted.
    int          m_mode;
    int          m_cnt;
    logic [15:0] m_pc;
    logic        m_v;
    logic [15:0] m_ipc;
    logic [15:0] m_ins;
    logic        m_boot;
    logic        m_halt;

    logic [15:0] mem [0:65535];
    logic [15:0] old16;
    logic [15:0] old18;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .imem_we        (imem_we),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .boot_done      (boot_done),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pc = 16'h0000; m_v = 1'b0;
        m_ipc = 16'h0000; m_ins = 16'h0000; m_boot = 1'b0; m_halt = 1'b0;
    endtask

    // One clock: check the memory-port outputs, predict the edge, then check IF/ID.
    task automatic cycle();
        logic        rdy;
        logic [15:0] word;
        int          n_mode, n_cnt;
        logic [15:0] n_pc, n_ipc, n_ins;
        logic        n_v, n_boot, n_halt;
        #1;
        rdy = (m_mode == 0) && (m_cnt < LW);
        chk("load_ready", 32'(load_ready), 32'(rdy));
        chk("imem_we", 32'(imem_we), 32'(rdy && load_valid));
        chk("imem_addr", 32'(imem_addr), (m_mode == 0) ? 32'(2 * m_cnt) : 32'(m_pc));
        if (rdy && load_valid) chk("imem_wdata", 32'(imem_wdata), 32'(load_data));
        n_mode = m_mode; n_cnt = m_cnt; n_pc = m_pc; n_v = m_v;
        n_ipc = m_ipc; n_ins = m_ins; n_boot = m_boot; n_halt = m_halt;
        if (rst) begin
            n_mode = 0; n_cnt = 0; n_pc = 16'h0000; n_v = 1'b0;
            n_ipc = 16'h0000; n_ins = 16'h0000; n_boot = 1'b0; n_halt = 1'b0;
        end else if (m_mode == 0) begin
            if (rdy && load_valid) begin
                n_cnt = m_cnt + 1;
                if (load_last || n_cnt == LW) begin
                    n_mode = 1; n_pc = 16'h0000; n_boot = 1'b1;
                end
            end
        end else if (redirect_valid) begin
            n_mode = 1; n_halt = 1'b0; n_v = 1'b0;
            n_pc = redirect_pc & 16'hFFFE;
        end else if (!stall) begin
            if (m_mode == 1) begin
                word  = mem[m_pc];
                n_v   = 1'b1;
                n_ipc = m_pc;
                n_ins = word;
                n_pc  = m_pc + 16'd2;
                if (word[15:12] == 4'hF) begin
                    n_mode = 2; n_halt = 1'b1;
                end
            end else begin
                n_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_cnt = n_cnt; m_pc = n_pc; m_v = n_v;
        m_ipc = n_ipc; m_ins = n_ins; m_boot = n_boot; m_halt = n_halt;
        chk("if_valid", 32'(if_valid), 32'(m_v));
        chk("if_pc", 32'(if_pc), 32'(m_ipc));
        chk("if_instr", 32'(if_instr), 32'(m_ins));
        chk("boot_done", 32'(boot_done), 32'(m_boot));
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic boot_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        cycle();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom_range(0, 16'hEFFF));
            if ($urandom_range(0, 31) == 0) w[15:12] = 4'hF;
            mem[i] = w;
        end
        mem[16'hFFFE] = 16'h2222;

        // Initial reset edge brings the DUT out of its power-up state.
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        // Three-word boot, last on the third.
        boot_word(16'h4010, 1'b0);
        boot_word(16'h5230, 1'b0);
        boot_word(16'h6450, 1'b1);
        chk("a_mem0", 32'(mem[0]), 32'h4010);
        chk("a_mem2", 32'(mem[2]), 32'h5230);
        chk("a_mem4", 32'(mem[4]), 32'h6450);
        chk("a_boot_done", 32'(boot_done), 32'd1);
        chk("a_gap_valid", 32'(if_valid), 32'd0);
        cycle();
        chk("a_first_valid", 32'(if_valid), 32'd1);
        chk("a_pc0", 32'(if_pc), 32'h0000);
        chk("a_ins0", 32'(if_instr), 32'h4010);
        cycle();
        chk("a_pc2", 32'(if_pc), 32'h0002);
        chk("a_ins2", 32'(if_instr), 32'h5230);
        cycle();
        chk("a_pc4", 32'(if_pc), 32'h0004);
        chk("a_ins4", 32'(if_instr), 32'h6450);

        // Ten words with no load_last: only the first eight are written.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        old16 = mem[16];
        old18 = mem[18];
        for (int i = 0; i < 10; i++) begin
            boot_word(16'h1100 + 16'(i), 1'b0);
            if (i == 7) chk("b_ready_after_8", 32'(load_ready), 32'd0);
        end
        for (int i = 0; i < 8; i++) chk("b_mem", 32'(mem[2 * i]), 32'h1100 + 32'(i));
        chk("b_mem16_kept", 32'(mem[16]), 32'(old16));
        chk("b_mem18_kept", 32'(mem[18]), 32'(old18));
        chk("b_pre_stall_pc", 32'(if_pc), 32'h0002);

        // Three stalled cycles at if_pc=2, then fetch resumes at 4.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("b_stall_pc", 32'(if_pc), 32'h0002);
            chk("b_stall_ins", 32'(if_instr), 32'h1101);
        end
        stall = 1'b0;
        cycle();
        chk("b_resume_pc", 32'(if_pc), 32'h0004);

        // Redirect to an odd target wins over a simultaneous stall.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0007;
        cycle();
        chk("b_bubble", 32'(if_valid), 32'd0);
        stall = 1'b0; redirect_valid = 1'b0;
        cycle();
        chk("b_redir_valid", 32'(if_valid), 32'd1);
        chk("b_redir_pc", 32'(if_pc), 32'h0006);
        chk("b_redir_ins", 32'(if_instr), 32'h1103);

        // Random stall/redirect traffic over the whole address space.
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = 16'($urandom);
            cycle();
        end
        stall = 1'b0; redirect_valid = 1'b0;

        // Top-of-memory wrap.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("w_pc_fffe", 32'(if_pc), 32'hFFFE);
        chk("w_ins_fffe", 32'(if_instr), 32'h2222);
        cycle();
        chk("w_pc_0000", 32'(if_pc), 32'h0000);
        chk("w_valid_0000", 32'(if_valid), 32'd1);

        // Mid-run reset returns to boot loading.
        rst = 1'b1;
        cycle();
        chk("r_if_valid", 32'(if_valid), 32'd0);
        chk("r_boot_done", 32'(boot_done), 32'd0);
        chk("r_load_ready", 32'(load_ready), 32'd1);
        rst = 1'b0;

        // HALT word at address 4, held by stall, then released by a redirect.
        boot_word(16'h4010, 1'b0);
        boot_word(16'h5230, 1'b0);
        boot_word(16'hF000, 1'b1);
        cycle();
        cycle();
        cycle();
        chk("h_valid", 32'(if_valid), 32'd1);
        chk("h_pc", 32'(if_pc), 32'h0004);
        chk("h_ins", 32'(if_instr), 32'hF000);
        chk("h_halted", 32'(halted), 32'd1);
        stall = 1'b1;
        cycle();
        cycle();
        chk("h_stall_hold", 32'(if_valid), 32'd1);
        stall = 1'b0;
        cycle();
        chk("h_drop_valid", 32'(if_valid), 32'd0);
        cycle();
        chk("h_still_halted", 32'(halted), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        cycle();
        chk("h_release", 32'(halted), 32'd0);
        redirect_valid = 1'b0;
        cycle();
        chk("h_restart_pc", 32'(if_pc), 32'h0000);
        chk("h_restart_ins", 32'(if_instr), 32'h4010);
        chk("h_restart_valid", 32'(if_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
